// File: rtl/bp_reg_burst.sv
// Bytepipe-attached register file with auto-incrementing burst read/write.
// Ports: i_clk, i_rst_n (async, active-low), i_cg (clock-gate enable),
//   host->dev i_bp_data/i_bp_valid/o_bp_ready, dev->host o_bp_data/o_bp_valid/i_bp_ready,
//   o_reg (flat register contents, reg k at [8k +: 8]), o_wrStrobe (per-register write pulse).
module bp_reg_burst #(
    parameter int          N_REG     = 128,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cg,
    input  logic [7:0]         i_bp_data,
    input  logic               i_bp_valid,
    output logic               o_bp_ready,
    output logic [7:0]         o_bp_data,
    output logic               o_bp_valid,
    input  logic               i_bp_ready,
    output logic [N_REG*8-1:0] o_reg,
    output logic [N_REG-1:0]   o_wrStrobe
);

    typedef enum logic [2:0] {CMD, LEN, WDATA, WACK, RDATA} state_t;

    state_t      state, stateNext;
    logic [6:0]  addr, addrNext;
    logic [7:0]  cnt, cntNext;
    logic [7:0]  lenReg, lenNext;
    logic        wrFlag, wrNext;
    logic        outValid, outValidNext;
    logic [7:0]  outData, outDataNext;
    logic        readyEn;
    logic [7:0]  regs [N_REG];
    logic [N_REG-1:0] wrStrobe;
    logic        inHs, outHs, wrHit, mapped;
    logic [7:0]  rdByte;

    // Ready only rises on the first edge after reset release.
    assign o_bp_ready = readyEn & i_cg
                      & ((state == CMD) | (state == LEN) | (state == WDATA));
    // Valid is masked while gated so no handshake can complete unseen.
    assign o_bp_valid = outValid & i_cg;
    assign o_bp_data  = outData;
    assign o_wrStrobe = wrStrobe & {N_REG{i_cg}};

    assign inHs   = i_bp_valid & o_bp_ready;
    assign outHs  = o_bp_valid & i_bp_ready;
    assign mapped = {1'b0, addr} < 8'(N_REG);
    assign wrHit  = (state == WDATA) & inHs & mapped;

    // Unmapped addresses read as zero.
    always_comb begin
        rdByte = '0;
        for (int k = 0; k < N_REG; k++) begin
            if (addr == 7'(k)) rdByte = regs[k];
        end
    end

    always_comb begin
        stateNext    = state;
        addrNext     = addr;
        cntNext      = cnt;
        lenNext      = lenReg;
        wrNext       = wrFlag;
        outValidNext = outValid;
        outDataNext  = outData;
        unique case (state)
            CMD: if (inHs) begin
                wrNext    = i_bp_data[7];
                addrNext  = i_bp_data[6:0];
                stateNext = LEN;
            end
            LEN: if (inHs) begin
                cntNext   = i_bp_data;
                lenNext   = i_bp_data;
                stateNext = wrFlag ? WDATA : RDATA;
            end
            WDATA: if (inHs) begin
                addrNext = addr + 7'd1;
                cntNext  = cnt - 8'd1;
                if (cnt == 8'd0) begin
                    stateNext    = WACK;
                    outValidNext = 1'b1;
                    outDataNext  = lenReg;
                end
            end
            WACK: if (outHs) begin
                outValidNext = 1'b0;
                stateNext    = CMD;
            end
            RDATA: begin
                // Load a byte, present it, then drop valid for one bubble.
                if (!outValid) begin
                    outValidNext = 1'b1;
                    outDataNext  = rdByte;
                end else if (outHs) begin
                    outValidNext = 1'b0;
                    addrNext     = addr + 7'd1;
                    cntNext      = cnt - 8'd1;
                    if (cnt == 8'd0) stateNext = CMD;
                end
            end
            default: stateNext = CMD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= CMD;
            addr     <= '0;
            cnt      <= '0;
            lenReg   <= '0;
            wrFlag   <= 1'b0;
            outValid <= 1'b0;
            outData  <= '0;
            readyEn  <= 1'b0;
        end else begin
            readyEn <= 1'b1;
            if (i_cg) begin
                state    <= stateNext;
                addr     <= addrNext;
                cnt      <= cntNext;
                lenReg   <= lenNext;
                wrFlag   <= wrNext;
                outValid <= outValidNext;
                outData  <= outDataNext;
            end
        end
    end

    // wrHit already implies i_cg, so the strobe clears on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_REG; k++) regs[k] <= RESET_VAL;
            wrStrobe <= '0;
        end else begin
            wrStrobe <= '0;
            for (int k = 0; k < N_REG; k++) begin
                if (wrHit && addr == 7'(k)) begin
                    regs[k]     <= i_bp_data;
                    wrStrobe[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_REG; k++) begin : g_out
        assign o_reg[8*k +: 8] = regs[k];
    end

endmodule

// File: tb/tb_bp_reg_burst.sv
// Bench for bp_reg_burst: two instances (128 and 100 registers) share one stimulus
// stream; a burst-level model of the register contents predicts every byte.
module tb_bp_reg_burst;

    logic          clk = 1'b0;
    logic          rstN = 1'b1;
    logic          cg = 1'b1;
    logic [7:0]    inData = '0;
    logic          inValid = 1'b0;
    logic          outReady = 1'b0;
    logic          readyA, readyB, outValidA, outValidB;
    logic [7:0]    outDataA, outDataB;
    logic [1023:0] regA;
    logic [799:0]  regB;
    logic [127:0]  strobeA;
    logic [99:0]   strobeB;

    int checks = 0;
    int errors = 0;
    bit rnd = 0;
    bit cgRnd = 0;
    logic [7:0] mA [128];
    logic [7:0] mB [100];

    always #5 clk = ~clk;

    bp_reg_burst #(.N_REG(128), .RESET_VAL(8'h00)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_cg(cg),
        .i_bp_data(inData), .i_bp_valid(inValid), .o_bp_ready(readyA),
        .o_bp_data(outDataA), .o_bp_valid(outValidA), .i_bp_ready(outReady),
        .o_reg(regA), .o_wrStrobe(strobeA)
    );

    bp_reg_burst #(.N_REG(100), .RESET_VAL(8'h00)) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_cg(cg),
        .i_bp_data(inData), .i_bp_valid(inValid), .o_bp_ready(readyB),
        .o_bp_data(outDataB), .o_bp_valid(outValidB), .i_bp_ready(outReady),
        .o_reg(regB), .o_wrStrobe(strobeB)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expB(input int a);
        return (a < 100) ? mB[a] : 8'h00;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 128; k++) mA[k] = 8'h00;
        for (int k = 0; k < 100; k++) mB[k] = 8'h00;
    endtask

    task automatic regCheck();
        for (int k = 0; k < 128; k++) chk("regA", 128'(regA[8*k +: 8]), 128'(mA[k]));
        for (int k = 0; k < 100; k++) chk("regB", 128'(regB[8*k +: 8]), 128'(mB[k]));
    endtask

    task automatic pickCg();
        cg = cgRnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            pickCg();
            inValid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            inData = b;
            #1;
            done = inValid && readyA;
            if (done) chk("readyB", 128'(readyB), 128'(1));
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        cg = 1'b1;
        chk("send_done", 128'(done), 128'(1));
    endtask

    task automatic recvByte(output logic [7:0] a, output logic [7:0] b);
        bit done = 0;
        bit stall = 0;
        logic [7:0] pd = '0;
        a = '0;
        b = '0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            pickCg();
            outReady = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            #1;
            if (cg) begin
                if (stall) begin
                    chk("hold_valid", 128'(outValidA), 128'(1));
                    chk("hold_data", 128'(outDataA), 128'(pd));
                end
                stall = outValidA && !outReady;
                pd = outDataA;
            end
            if (outValidA && outReady) begin
                done = 1;
                a = outDataA;
                b = outDataB;
                chk("validB", 128'(outValidB), 128'(1));
            end
            @(posedge clk);
            #1;
        end
        outReady = 1'b0;
        cg = 1'b1;
        chk("recv_done", 128'(done), 128'(1));
    endtask

    task automatic burstWrite(input int a, input int n, input bit seq);
        logic [7:0] d, ra, rb;
        int ad;
        sendByte({1'b1, 7'(a)});
        sendByte(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            d = seq ? 8'(i) : 8'($urandom);
            sendByte(d);
            ad = (a + i) % 128;
            mA[ad] = d;
            if (ad < 100) mB[ad] = d;
        end
        recvByte(ra, rb);
        chk("ackA", 128'(ra), 128'(n - 1));
        chk("ackB", 128'(rb), 128'(n - 1));
        regCheck();
    endtask

    task automatic burstRead(input int a, input int n);
        logic [7:0] ra, rb;
        int ad;
        sendByte({1'b0, 7'(a)});
        sendByte(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            recvByte(ra, rb);
            ad = (a + i) % 128;
            chk("rdA", 128'(ra), 128'(mA[ad]));
            chk("rdB", 128'(rb), 128'(expB(ad)));
        end
    endtask

    task automatic resetAssert();
        inValid = 1'b0;
        outReady = 1'b0;
        cg = 1'b1;
        rstN = 1'b0;
        #1;
        modelClear();
        chk("rst_validA", 128'(outValidA), 128'(0));
        chk("rst_validB", 128'(outValidB), 128'(0));
        chk("rst_dataA", 128'(outDataA), 128'(0));
        chk("rst_readyA", 128'(readyA), 128'(0));
        chk("rst_strobeA", strobeA, 128'(0));
        chk("rst_strobeB", 128'(strobeB), 128'(0));
        regCheck();
    endtask

    task automatic resetRelease();
        @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("rel_ready_pre", 128'(readyA), 128'(0));
        @(posedge clk);
        #1;
        chk("rel_readyA", 128'(readyA), 128'(1));
        chk("rel_readyB", 128'(readyB), 128'(1));
    endtask

    initial begin
        logic [7:0] ra, rb;
        modelClear();

        // power-on reset
        #1;
        resetAssert();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_clk", 128'(readyA), 128'(0));
        resetRelease();

        // read-command with wr=0 returns zeros, then a real write
        burstRead(5, 2);
        sendByte(8'h85);
        sendByte(8'h01);
        sendByte(8'hAA);
        chk("wr_reg5", 128'(regA[40 +: 8]), 128'(8'hAA));
        chk("strobe5A", strobeA, 128'(1) << 5);
        chk("strobe5B", 128'(strobeB), 128'(1) << 5);
        sendByte(8'hBB);
        chk("wr_reg6", 128'(regA[48 +: 8]), 128'(8'hBB));
        chk("strobe6A", strobeA, 128'(1) << 6);
        @(posedge clk);
        #1;
        chk("strobe_off", strobeA, 128'(0));
        recvByte(ra, rb);
        chk("ack01", 128'(ra), 128'(8'h01));
        mA[5] = 8'hAA; mA[6] = 8'hBB;
        mB[5] = 8'hAA; mB[6] = 8'hBB;
        regCheck();

        // same value again still strobes
        sendByte(8'h85);
        sendByte(8'h00);
        sendByte(8'hAA);
        chk("restrobe5", strobeA, 128'(1) << 5);
        recvByte(ra, rb);
        chk("ack00", 128'(ra), 128'(8'h00));

        // full 256-byte burst, last write wins
        burstWrite(0, 256, 1'b1);
        chk("full_reg0", 128'(regA[0 +: 8]), 128'(8'h80));
        burstRead(0, 256);

        // address wrap and unmapped gaps
        burstRead(127, 2);
        burstRead(98, 4);

        // reset while a read byte is presented
        sendByte(8'h05);
        sendByte(8'h01);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 128'(outValidA), 128'(1));
        #3;
        resetAssert();
        resetRelease();

        // reset mid-write burst, then a fresh command
        sendByte(8'h81);
        sendByte(8'h05);
        sendByte(8'h44);
        sendByte(8'h55);
        chk("partial_reg2", 128'(regA[16 +: 8]), 128'(8'h55));
        #3;
        resetAssert();
        resetRelease();
        sendByte(8'h81);
        sendByte(8'h00);
        sendByte(8'h11);
        recvByte(ra, rb);
        chk("ack_after_rst", 128'(ra), 128'(8'h00));
        mA[1] = 8'h11;
        mB[1] = 8'h11;
        regCheck();

        // random bursts with backpressure and clock gating
        rnd = 1;
        cgRnd = 1;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1)
                burstWrite(int'($urandom_range(0, 127)), int'($urandom_range(1, 64)), 1'b0);
            else
                burstRead(int'($urandom_range(0, 127)), int'($urandom_range(1, 64)));
        end
        burstWrite(120, 20, 1'b0);
        burstRead(126, 6);
        burstRead(97, 5);
        rnd = 0;
        cgRnd = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
